mem_sequencer: RTL and testbench

MEM_SEQUENCER -- requirements
Module: mem_sequencer

---
 rtl/mem_sequencer.sv | 95 +++++++++
 tb/tb_mem_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_sequencer.sv
// mem_sequencer: sequences two-byte instruction fetches, byte loads and byte stores
// over a single-port memory with combinational read data.
module mem_sequencer #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req,
    input  logic [1:0]          cmd,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic                mem_we,
    output logic [2*DATA_W-1:0] instr,
    output logic [ADDR_W-1:0]   next_pc,
    output logic [DATA_W-1:0]   rdata,
    output logic                busy,
    output logic                done
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] F_HI = 3'd1;
    localparam logic [2:0] F_LO = 3'd2;
    localparam logic [2:0] LD   = 3'd3;
    localparam logic [2:0] ST   = 3'd4;
    localparam logic [2:0] DONE = 3'd5;

    logic [2:0]          state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [2*DATA_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]   next_pc_q, next_pc_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        instr_d   = instr_q;
        next_pc_d = next_pc_q;
        rdata_d   = rdata_q;
        case (state_q)
            IDLE: if (req && cmd != 2'b11) begin
                addr_d  = addr;
                wdata_d = wdata;
                state_d = (cmd == 2'b00) ? F_HI : (cmd == 2'b01) ? LD : ST;
            end
            F_HI: begin
                instr_d[2*DATA_W-1:DATA_W] = mem_rdata;
                state_d = F_LO;
            end
            F_LO: begin
                instr_d[DATA_W-1:0] = mem_rdata;
                next_pc_d = addr_q + ADDR_W'(2);
                state_d = DONE;
            end
            LD: begin
                rdata_d = mem_rdata;
                state_d = DONE;
            end
            ST:      state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            instr_q   <= '0;
            next_pc_q <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            instr_q   <= instr_d;
            next_pc_q <= next_pc_d;
            rdata_q   <= rdata_d;
        end
    end

    // Only the low byte of a fetch sits at the incremented address; every other state presents the latched one.
    assign mem_addr  = (state_q == F_LO) ? addr_q + ADDR_W'(1) : addr_q;
    assign mem_wdata = wdata_q;
    assign mem_we    = (state_q == ST);
    assign instr     = instr_q;
    assign next_pc   = next_pc_q;
    assign rdata     = rdata_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
endmodule

// File: tb/tb_mem_sequencer.sv
// tb_mem_sequencer: scoreboard bench for mem_sequencer against a behavioural 8K x 8 memory.
module tb_mem_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic [1:0]  cmd = 2'b11;
    logic [12:0] addr = '0;
    logic [7:0]  wdata = '0;
    logic [7:0]  mem_rdata;
    logic [12:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [15:0] instr;
    logic [12:0] next_pc;
    logic [7:0]  rdata;
    logic        busy;
    logic        done;

    typedef struct packed {
        logic [15:0] instr;
        logic [12:0] npc;
        logic [7:0]  rdata;
    } exp_t;

    exp_t sb[$];
    exp_t cur = '0;
    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    int done_cnt = 0;
    logic [7:0] mem [0:8191];

    mem_sequencer #(.ADDR_W(13), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .req(req), .cmd(cmd), .addr(addr), .wdata(wdata),
        .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .instr(instr), .next_pc(next_pc), .rdata(rdata), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_we === 1'b1) we_cnt++;
        if (done === 1'b1) done_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // Issues one command and follows it until busy drops, recording what was seen at done.
    task automatic run_op(input logic [1:0] c, input logic [12:0] a, input logic [7:0] w,
                          input bit release_rst, output int lat, output int busy_n,
                          output int done_n, output exp_t got);
        lat = -1;
        busy_n = 0;
        done_n = 0;
        got = '0;
        @(negedge clk);
        if (release_rst) rst = 1'b1;
        req = 1'b1;
        cmd = c;
        addr = a;
        wdata = w;
        @(negedge clk);
        req = 1'b0;
        cmd = 2'b11;
        addr = 13'($urandom);
        wdata = 8'($urandom);
        for (int k = 0; k < 10 && busy === 1'b1; k++) begin
            busy_n++;
            if (done === 1'b1) begin
                done_n++;
                lat = k;
                got = {instr, next_pc, rdata};
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, mem_we} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl: busy/done/we got %b expected 000", {busy, done, mem_we});
        end
        checks++;
        if ({instr, next_pc, rdata, mem_addr, mem_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_data: instr=%h next_pc=%h rdata=%h mem_addr=%h mem_wdata=%h expected all 0",
                     instr, next_pc, rdata, mem_addr, mem_wdata);
        end
    endtask

    task automatic test_fetch;
        int lat, bn, dn;
        exp_t got, e;
        mem[0] = 8'hE0;
        mem[1] = 8'h43;
        cur = '{16'hE043, 13'd2, cur.rdata};
        sb.push_back(cur);
        run_op(2'b00, 13'd0, 8'h00, 1'b1, lat, bn, dn, got);
        e = sb.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL fetch_result: got %h expected %h", got, e);
        end
        checks++;
        if (lat !== 2 || bn !== 3 || dn !== 1) begin
            errors++;
            $display("FAIL fetch_timing: lat=%0d busy=%0d dones=%0d expected 2/3/1", lat, bn, dn);
        end
    endtask

    task automatic test_fetch_wrap;
        int lat, bn, dn;
        exp_t got, e;
        mem[8191] = 8'hAB;
        mem[0] = 8'hCD;
        cur = '{16'hABCD, 13'd1, cur.rdata};
        sb.push_back(cur);
        run_op(2'b00, 13'd8191, 8'h00, 1'b0, lat, bn, dn, got);
        e = sb.pop_front();
        checks++;
        if (got !== e || lat !== 2) begin
            errors++;
            $display("FAIL fetch_wrap: got %h lat=%0d expected %h lat=2", got, lat, e);
        end
    endtask

    task automatic test_store_load;
        int lat, bn, dn, w0;
        exp_t got, e;
        w0 = we_cnt;
        mem[2000] = 8'h00;
        sb.push_back(cur);
        run_op(2'b10, 13'd2000, 8'h5A, 1'b0, lat, bn, dn, got);
        e = sb.pop_front();
        checks++;
        if (got !== e || lat !== 1 || bn !== 2 || dn !== 1) begin
            errors++;
            $display("FAIL store_op: got %h lat=%0d busy=%0d dones=%0d expected %h 1/2/1", got, lat, bn, dn, e);
        end
        checks++;
        if (we_cnt - w0 !== 1 || mem[2000] !== 8'h5A) begin
            errors++;
            $display("FAIL store_write: we cycles=%0d mem=%h expected 1 and 5a", we_cnt - w0, mem[2000]);
        end
        cur.rdata = 8'h5A;
        sb.push_back(cur);
        run_op(2'b01, 13'd2000, 8'h00, 1'b0, lat, bn, dn, got);
        e = sb.pop_front();
        checks++;
        if (got !== e || lat !== 1 || bn !== 2 || dn !== 1) begin
            errors++;
            $display("FAIL load_op: got %h lat=%0d busy=%0d dones=%0d expected %h 1/2/1", got, lat, bn, dn, e);
        end
    endtask

    task automatic test_reserved;
        int d0;
        bit seen_busy;
        d0 = done_cnt;
        seen_busy = 1'b0;
        @(negedge clk);
        req = 1'b1;
        cmd = 2'b11;
        addr = 13'd77;
        repeat (4) begin
            @(negedge clk);
            if (busy !== 1'b0) seen_busy = 1'b1;
        end
        req = 1'b0;
        checks++;
        if (seen_busy || done_cnt !== d0 || mem_addr !== 13'd2000) begin
            errors++;
            $display("FAIL reserved_cmd: busy_seen=%0b dones=%0d mem_addr=%0d expected 0/0/2000",
                     seen_busy, done_cnt - d0, mem_addr);
        end
    endtask

    task automatic test_back_to_back;
        int d0;
        exp_t e;
        mem[1000] = 8'h1A;
        mem[5] = 8'h77;
        d0 = done_cnt;
        @(negedge clk);
        req = 1'b1;
        cmd = 2'b01;
        addr = 13'd1000;
        cur.rdata = 8'h1A;
        sb.push_back(cur);
        @(negedge clk);
        addr = 13'd5;
        cur.rdata = 8'h77;
        sb.push_back(cur);
        #1;
        checks++;
        if (busy !== 1'b1 || mem_addr !== 13'd1000) begin
            errors++;
            $display("FAIL held_latch: busy=%b mem_addr=%0d expected 1 and 1000", busy, mem_addr);
        end
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (done !== 1'b1 || {instr, next_pc, rdata} !== e) begin
            errors++;
            $display("FAIL held_first: done=%b got %h expected 1 and %h", done, {instr, next_pc, rdata}, e);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL held_idle: busy=%b expected 0 after done", busy);
        end
        @(negedge clk);
        req = 1'b0;
        checks++;
        if (busy !== 1'b1 || mem_addr !== 13'd5) begin
            errors++;
            $display("FAIL held_second_accept: busy=%b mem_addr=%0d expected 1 and 5", busy, mem_addr);
        end
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (done !== 1'b1 || {instr, next_pc, rdata} !== e) begin
            errors++;
            $display("FAIL held_second: done=%b got %h expected 1 and %h", done, {instr, next_pc, rdata}, e);
        end
        @(negedge clk);
        checks++;
        if (done_cnt - d0 !== 2 || busy !== 1'b0) begin
            errors++;
            $display("FAIL held_done_count: dones=%0d busy=%b expected 2 and 0", done_cnt - d0, busy);
        end
    endtask

    task automatic test_reset_mid;
        int d0, w0;
        d0 = done_cnt;
        @(negedge clk);
        req = 1'b1;
        cmd = 2'b00;
        addr = 13'd0;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        cur = '0;
        checks++;
        if (busy !== 1'b0 || {instr, next_pc, rdata} !== cur) begin
            errors++;
            $display("FAIL reset_fetch: busy=%b got %h expected 0 and %h", busy, {instr, next_pc, rdata}, cur);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (done_cnt !== d0) begin
            errors++;
            $display("FAIL reset_fetch_done: dones=%0d expected 0", done_cnt - d0);
        end
        @(negedge clk);
        req = 1'b1;
        cmd = 2'b10;
        addr = 13'd300;
        wdata = 8'h99;
        @(negedge clk);
        req = 1'b0;
        w0 = we_cnt;
        checks++;
        if (mem_we !== 1'b1) begin
            errors++;
            $display("FAIL reset_st_we: mem_we=%b expected 1 in ST", mem_we);
        end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (we_cnt - w0 !== 1 || busy !== 1'b0 || done_cnt !== d0) begin
            errors++;
            $display("FAIL reset_st: we cycles=%0d busy=%b dones=%0d expected 1/0/0", we_cnt - w0, busy, done_cnt - d0);
        end
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 8'(i * 7 + 3);
        test_reset;
        test_fetch;
        test_fetch_wrap;
        test_store_load;
        test_reserved;
        test_back_to_back;
        test_reset_mid;
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
